prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the CPU instruction-memory interface: the CPU fetches opcode/operand nibble pairs from memory; this block fills that memory.
- Accepts a framed byte stream on a valid/ready handshake: one length byte, N instruction bytes, one checksum byte.
- Splits each instruction byte into opcode and operand nibbles and writes them to consecutive memory addresses.
- Holds the CPU in reset until a frame completes with a correct checksum.

Parameters:
- ADDR_W, 4: instruction-memory address width. Memory depth is 2**ADDR_W nibbles.
- DATA_W, 4: memory word width (one nibble). The input byte width is 2*DATA_W.
- MAX_INSTR, 2**(ADDR_W-1): largest legal length byte. Default is 8.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset. reset=0 asserts.
- start, input, 1: single-cycle pulse that begins a load. Sampled only in IDLE, DONE and ERR.
- in_data, input, 2*DATA_W: stream byte.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: loader can accept a byte. A transfer occurs on an edge where in_valid and in_ready are both 1.
- mem_we, output, 1: instruction-memory write strobe, one cycle per nibble.
- mem_addr, output, ADDR_W: write address.
- mem_wdata, output, DATA_W: write data.
- cpu_hold, output, 1: 1 holds the CPU in reset.
- busy, output, 1: a load is in progress.
- done, output, 1: last frame loaded successfully. Level output.
- error, output, 1: last frame failed. Level output.

Behaviour:
- Reset values: state=IDLE, cpu_hold=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, internal count=0, checksum accumulator=0.
- All outputs are registered.
- FSM states: IDLE, LEN, DATA, WR_HI, WR_LO, CHK, DONE, ERR.
- IDLE, DONE, ERR on start=1:
  - next state LEN; cpu_hold=1; done=0; error=0; busy=1; address pointer=0; checksum accumulator=0.
- LEN: in_ready=1. On transfer:
  - acc=byte; N=byte.
  - N>MAX_INSTR: go to ERR. No writes occur.
  - N=0: go to CHK.
  - Otherwise: go to DATA.
- DATA: in_ready=1. On transfer:
  - Latch the byte; acc ^= byte; go to WR_HI.
- WR_HI: in_ready=0.
  - mem_we=1, mem_addr=2k, mem_wdata=byte[2*DATA_W-1:DATA_W] (the opcode).
  - Go to WR_LO.
- WR_LO: in_ready=0.
  - mem_we=1, mem_addr=2k+1, mem_wdata=byte[DATA_W-1:0] (the operand).
  - k++. If k==N go to CHK, else go to DATA.
- Write latency and throughput:
  - The high-nibble write strobe is asserted in the cycle after the accepting edge; the low-nibble write follows in the next cycle.
  - Maximum rate is one byte per 3 cycles.
- CHK: in_ready=1. On transfer:
  - byte==acc: go to DONE.
  - Otherwise: go to ERR.
- DONE: done=1, cpu_hold=0, busy=0, in_ready=0.
  - done rises in the cycle after the checksum-accepting edge.
- ERR: error=1, cpu_hold=1, busy=0, in_ready=0.
- Address arithmetic:
  - Addresses are ADDR_W bits and never wrap, because N<=MAX_INSTR guarantees 2N<=2**ADDR_W.
- Handshake rules:
  - in_valid low stalls the FSM indefinitely with no timeout.
  - in_data is ignored whenever in_ready=0.
- start outside IDLE/DONE/ERR is ignored.
- An in_valid pulse in IDLE, DONE or ERR is not consumed.
- start together with in_valid in IDLE: only start acts. The byte is not consumed on that edge because in_ready=0.
- Reset asserted mid-load:
  - Everything returns to reset values immediately (asynchronous); cpu_hold=1.
  - Memory nibbles already written are left in place. No completion is reported.
- mem_we is never asserted outside WR_HI and WR_LO.

Test Plan:
- Reset, start, stream 06,13,20,50,30,40,70 then checksum 65 with in_valid held high:
  - 12 writes, in order addr0..11 = 1,3,2,0,5,0,3,0,4,0,7,0.
  - done=1 and cpu_hold=0 one cycle after the 65 transfer; error=0.
- Same frame with checksum 64:
  - All 12 writes occur.
  - Then error=1, done=0, cpu_hold stays 1.
- Length byte 09:
  - error=1 the cycle after the transfer.
  - Zero mem_we pulses; in_ready=0 afterwards.
- Length 00, checksum 00:
  - done=1 with no writes.
  - With checksum 01 instead: error=1.
- Frame 02,A5,3C,9B with in_valid low for 4 cycles between each byte:
  - Writes 0:A, 1:5, 2:3, 3:C.
  - done=1; no byte consumed while in_valid=0.
- Assert reset after the second data byte's WR_HI cycle:
  - Outputs return to reset values asynchronously; cpu_hold=1; done=0; busy=0.
  - A subsequent full valid frame completes normally.
  - A start pulse issued mid-frame is ignored (busy stays 1, address pointer unchanged).

Source files
------------

// File: rtl/prog_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prog_loader_if : byte-stream input and instruction-memory write bus  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface prog_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic [2*DATA_W-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prog_loader : loads a framed byte stream into nibble instruction     |
// | memory and holds the CPU in reset until the checksum matches.        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module prog_loader #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int MAX_INSTR = 2**(ADDR_W-1)
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         start,
    prog_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int BYTE_W = 2*DATA_W;
    localparam logic [BYTE_W-1:0] c_max_len = BYTE_W'(MAX_INSTR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WR_HI = 3'd3,
        S_WR_LO = 3'd4,
        S_CHK   = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t              r_state, w_state_n;
    logic [ADDR_W-1:0]   r_k, w_k_n, w_k_inc;
    logic [BYTE_W-1:0]   r_len, w_len_n;
    logic [BYTE_W-1:0]   r_acc, w_acc_n;
    logic [BYTE_W-1:0]   r_byte, w_byte_n;
    logic                w_xfer;
    logic                w_in_ready_n, w_mem_we_n;
    logic [ADDR_W-1:0]   w_mem_addr_n;
    logic [DATA_W-1:0]   w_mem_wdata_n;

    assign w_xfer  = bus.in_valid & bus.in_ready;
    assign w_k_inc = r_k + 1'b1;

    always_comb begin
        w_state_n = r_state;
        w_k_n     = r_k;
        w_len_n   = r_len;
        w_acc_n   = r_acc;
        w_byte_n  = r_byte;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_n = S_LEN;
                    w_k_n     = '0;
                    w_acc_n   = '0;
                end
            end
            S_LEN: begin
                if (w_xfer) begin
                    w_acc_n = bus.in_data;
                    w_len_n = bus.in_data;
                    if (bus.in_data > c_max_len)
                        w_state_n = S_ERR;
                    else if (bus.in_data == '0)
                        w_state_n = S_CHK;
                    else
                        w_state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    w_byte_n  = bus.in_data;
                    w_acc_n   = r_acc ^ bus.in_data;
                    w_state_n = S_WR_HI;
                end
            end
            S_WR_HI: w_state_n = S_WR_LO;
            S_WR_LO: begin
                w_k_n     = w_k_inc;
                w_state_n = (BYTE_W'(w_k_inc) == r_len) ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (w_xfer)
                    w_state_n = (bus.in_data == r_acc) ? S_DONE : S_ERR;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_comb begin
        w_in_ready_n  = (w_state_n == S_LEN) || (w_state_n == S_DATA) || (w_state_n == S_CHK);
        w_mem_we_n    = (w_state_n == S_WR_HI) || (w_state_n == S_WR_LO);
        w_mem_addr_n  = bus.mem_addr;
        w_mem_wdata_n = bus.mem_wdata;
        if (w_state_n == S_WR_HI) begin
            w_mem_addr_n  = {r_k[ADDR_W-2:0], 1'b0};
            w_mem_wdata_n = w_byte_n[BYTE_W-1:DATA_W];
        end else if (w_state_n == S_WR_LO) begin
            w_mem_addr_n  = {r_k[ADDR_W-2:0], 1'b1};
            w_mem_wdata_n = w_byte_n[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_len         <= '0;
            r_acc         <= '0;
            r_byte        <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_hold      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_k           <= w_k_n;
            r_len         <= w_len_n;
            r_acc         <= w_acc_n;
            r_byte        <= w_byte_n;
            bus.in_ready  <= w_in_ready_n;
            bus.mem_we    <= w_mem_we_n;
            bus.mem_addr  <= w_mem_addr_n;
            bus.mem_wdata <= w_mem_wdata_n;
            cpu_hold      <= (w_state_n != S_DONE);
            busy          <= (w_state_n != S_IDLE) && (w_state_n != S_DONE) && (w_state_n != S_ERR);
            done          <= (w_state_n == S_DONE);
            error         <= (w_state_n == S_ERR);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_prog_loader : scoreboard bench for prog_loader                    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_prog_loader;
    logic clk;
    logic reset;
    logic start;
    logic cpu_hold, busy, done, error;

    prog_loader_if #(.ADDR_W(4), .DATA_W(4)) bus();

    prog_loader #(.ADDR_W(4), .DATA_W(4), .MAX_INSTR(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q_wr[$];      // {addr, data}
    logic [3:0] q_st[$];      // {done, error, cpu_hold, busy}
    logic       prev_done = 1'b0;
    logic       prev_err  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.mem_we === 1'b1) begin
            if (q_wr.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", bus.mem_addr, bus.mem_wdata);
            end else begin
                chk("mem_write", {24'd0, bus.mem_addr, bus.mem_wdata}, {24'd0, q_wr.pop_front()});
            end
        end
    end

    // Completion monitor
    always @(negedge clk) begin
        if (reset === 1'b1 && ((done && !prev_done) || (error && !prev_err))) begin
            if (q_st.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_status: got %b expected none", {done, error, cpu_hold, busy});
            end else begin
                chk("status", {28'd0, done, error, cpu_hold, busy}, {28'd0, q_st.pop_front()});
            end
        end
        prev_done = done;
        prev_err  = error;
    end

    task automatic push_wr(input logic [3:0] a, input logic [3:0] d);
        q_wr.push_back({a, d});
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called and returns at a negedge; returns right after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 for byte %0h", b);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        idle(4);
        chk({name, "_writes_drained"}, q_wr.size(), 0);
        chk({name, "_status_drained"}, q_st.size(), 0);
    endtask

    logic [7:0] frame_a[7] = '{8'h06, 8'h13, 8'h20, 8'h50, 8'h30, 8'h40, 8'h70};
    logic [3:0] wr_a[12]   = '{4'h1, 4'h3, 4'h2, 4'h0, 4'h5, 4'h0, 4'h3, 4'h0, 4'h4, 4'h0, 4'h7, 4'h0};

    task automatic push_frame_a();
        for (int i = 0; i < 12; i++) push_wr(4'(i), wr_a[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        #12;
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_busy_done_err", {busy, done, error}, 0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        chk("idle_in_ready", bus.in_ready, 0);

        // Good frame, in_valid held high throughout
        push_frame_a();
        q_st.push_back(4'b1000);
        do_start();
        chk("start_busy", busy, 1);
        for (int i = 0; i < 7; i++) send_byte(frame_a[i]);
        send_byte(8'h65);
        chk("a_done_latency", {done, error, cpu_hold, busy, bus.in_ready}, 5'b10000);
        drain("a");

        // Same frame, bad checksum
        push_frame_a();
        q_st.push_back(4'b0110);
        do_start();
        for (int i = 0; i < 7; i++) send_byte(frame_a[i]);
        send_byte(8'h64);
        chk("bad_chk_result", {done, error, cpu_hold}, 3'b011);
        drain("bad_chk");

        // Oversize length
        q_st.push_back(4'b0110);
        do_start();
        send_byte(8'h09);
        chk("len9_error", {done, error, cpu_hold}, 3'b011);
        idle(1);
        chk("len9_in_ready", bus.in_ready, 0);
        drain("len9");

        // Empty frame, good and bad checksum
        q_st.push_back(4'b1000);
        do_start();
        send_byte(8'h00);
        send_byte(8'h00);
        chk("len0_done", {done, error}, 2'b10);
        drain("len0_ok");
        q_st.push_back(4'b0110);
        do_start();
        send_byte(8'h00);
        send_byte(8'h01);
        chk("len0_err", {done, error}, 2'b01);
        drain("len0_bad");

        // Gapped frame
        push_wr(4'h0, 4'hA); push_wr(4'h1, 4'h5); push_wr(4'h2, 4'h3); push_wr(4'h3, 4'hC);
        q_st.push_back(4'b1000);
        do_start();
        send_byte(8'h02); idle(4);
        send_byte(8'hA5); idle(4);
        send_byte(8'h3C); idle(4);
        send_byte(8'h9B);
        chk("gap_done", {done, error, cpu_hold}, 3'b100);
        drain("gap");

        // Reset in the cycle after the second data byte's high-nibble write
        push_wr(4'h0, 4'h1); push_wr(4'h1, 4'h3); push_wr(4'h2, 4'h2);
        do_start();
        send_byte(8'h06);
        send_byte(8'h13);
        send_byte(8'h20);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_outputs", {cpu_hold, busy, done, error, bus.in_ready, bus.mem_we},
            6'b100000);
        chk("mid_rst_addr_data", {bus.mem_addr, bus.mem_wdata}, 0);
        @(negedge clk);
        reset = 1'b1;
        drain("mid_rst");

        // Full frame with an ignored start pulse mid-frame
        push_frame_a();
        q_st.push_back(4'b1000);
        do_start();
        send_byte(frame_a[0]);
        bus.in_valid = 1'b0;
        do_start();
        chk("mid_start_busy", {busy, bus.in_ready}, 2'b11);
        for (int i = 1; i < 7; i++) send_byte(frame_a[i]);
        send_byte(8'h65);
        chk("final_done", {done, error, cpu_hold}, 3'b100);
        drain("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
